// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit path.
//   state_t       : serializer FSM states (IDLE, SHIFT)
//   DEFAULT_WIDTH : default data word width
//   PARITY_ON     : 1 when the PARITY_EN macro is defined (even parity bit appended)
//   frame_len()   : number of serial bits per frame for a given width/parity
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

`ifdef PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif

    function automatic int frame_len(input int width, input bit parity);
        return parity ? width + 1 : width;
    endfunction

endpackage

// File: rtl/byte_serializer.sv
// Parallel-to-serial transmitter with a valid/ready load interface.
// A word accepted on load_valid && load_ready is shifted out one bit per
// clock starting the cycle after the accept edge. A new word may be accepted
// in the last-bit cycle so frames run back to back with no gap.
//
// Optional feature: define PARITY_EN to append an even-parity bit (XOR of
// the data bits captured at accept) after the last data bit.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   data       in   WIDTH-bit word, sampled only on an accepted load
//   load_valid in   data valid
//   load_ready out  can accept a word this cycle (IDLE or last-bit cycle)
//   sout       out  serial bit (0 when idle)
//   sout_valid out  sout carries a frame bit
//   done       out  pulse coincident with the last frame bit
//   busy       out  frame in progress (same as sout_valid)
//
// state | meaning
// IDLE  | no frame in flight, ready for a word
// SHIFT | driving frame bits; counter==0 marks the last bit
module byte_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done,
    output logic             busy
);

    localparam int                FRAME    = frame_len(WIDTH, PARITY_ON);
    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(FRAME - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FRAME-1:0]   r_shift;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_last;
    logic               w_accept;
    logic [FRAME-1:0]   w_load;
    logic [FRAME-1:0]   w_shift_nxt;
    logic               w_bit;

    assign w_last   = (r_state == SHIFT) && (r_cnt == '0);
    assign w_accept = load_valid && load_ready;

    // The parity bit sits at the tail end of the register so it leaves
    // after the last data bit in either bit order.
`ifdef PARITY_EN
    logic w_parity;
    assign w_parity = ^data;
    assign w_load   = MSB_FIRST ? {data, w_parity} : {w_parity, data};
`else
    assign w_load   = data;
`endif

    assign w_shift_nxt = MSB_FIRST ? {r_shift[FRAME-2:0], 1'b0}
                                   : {1'b0, r_shift[FRAME-1:1]};
    assign w_bit       = MSB_FIRST ? r_shift[FRAME-1] : r_shift[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == '0) w_state_nxt = w_accept ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: shift register and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shift <= w_load;
            r_cnt   <= CNT_LOAD;
        end else if (r_state == SHIFT) begin
            // Shifting on the final bit leaves the register empty for IDLE.
            r_shift <= w_shift_nxt;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        load_ready = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        case (r_state)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                sout       = w_bit;
                sout_valid = 1'b1;
                busy       = 1'b1;
                done       = w_last;
                load_ready = w_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_byte_serializer.sv
module tb_byte_serializer;

`ifdef PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data;
    logic         load_valid;

    logic m_ready, m_sout, m_valid, m_done, m_busy;
    logic l_ready, l_sout, l_valid, l_done, l_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: queue of bits still to be sent for each bit order.
    bit q_msb[$];
    bit q_lsb[$];
    bit last_acc;

    always #5 clk = ~clk;

    byte_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .data(data), .load_valid(load_valid),
        .load_ready(m_ready), .sout(m_sout), .sout_valid(m_valid),
        .done(m_done), .busy(m_busy)
    );

    byte_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .data(data), .load_valid(load_valid),
        .load_ready(l_ready), .sout(l_sout), .sout_valid(l_valid),
        .done(l_done), .busy(l_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_dut(input string name, input bit q[$],
                             input logic rdy, input logic so, input logic sv,
                             input logic dn, input logic bz);
        bit e_valid;
        bit e_sout;
        e_valid = (q.size() > 0);
        e_sout  = e_valid ? q[0] : 1'b0;
        check({name, "_sout"},  32'(so),  32'(e_sout));
        check({name, "_valid"}, 32'(sv),  32'(e_valid));
        check({name, "_busy"},  32'(bz),  32'(e_valid));
        check({name, "_done"},  32'(dn),  32'(q.size() == 1));
        check({name, "_ready"}, 32'(rdy), 32'(q.size() <= 1));
    endtask

    // Called at a negedge: check outputs, apply inputs for the next edge,
    // advance the model across that edge, then wait for the next negedge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
        bit acc;
        check_dut("msb", q_msb, m_ready, m_sout, m_valid, m_done, m_busy);
        check_dut("lsb", q_lsb, l_ready, l_sout, l_valid, l_done, l_busy);
        load_valid = v;
        data       = d;
        rst        = r;
        acc = v && !r && (q_msb.size() <= 1);
        if (r) begin
            q_msb.delete();
            q_lsb.delete();
        end else begin
            if (q_msb.size() > 0) void'(q_msb.pop_front());
            if (q_lsb.size() > 0) void'(q_lsb.pop_front());
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    q_msb.push_back(d[W-1-i]);
                    q_lsb.push_back(d[i]);
                end
                if (PAR) begin
                    q_msb.push_back(^d);
                    q_lsb.push_back(^d);
                end
            end
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    // Hold load_valid with d until accepted (bounded).
    task automatic send(input logic [W-1:0] d);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            cycle(1'b1, d, 1'b0);
            got = last_acc;
        end
        check("send_accept", 32'(got), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        data       = '0;
        @(negedge clk);

        cycle(1'b0, 8'h00, 1'b1);
        idle(2);

        send(8'hA5); idle(12);
        send(8'h01); idle(12);

        // back to back, valid held high
        send(8'hFF); send(8'h00); idle(12);

        // request mid-frame while not ready
        send(8'hA5); idle(3); send(8'h3C); idle(12);

        // reset in cycle 4 of a frame
        send(8'hA5); idle(2);
        cycle(1'b0, 8'h00, 1'b1);
        idle(2);
        send(8'h81); idle(12);

        // reset coincident with a load request
        cycle(1'b1, 8'h5A, 1'b1);
        idle(3);

        // parity patterns (plain data frames when parity is off)
        send(8'h07); idle(11);
        send(8'h03); idle(11);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 2) != 0), 8'($urandom),
                  1'($urandom_range(0, 99) == 0));
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/byte_serializer.md
# byte_serializer

Parallel-to-serial transmitter for the 8-bit register path. Accepts a word on a valid/ready load interface, holds it in an internal shift register, and drives it out one bit per clock with a qualifying valid strobe. It sits downstream of the enable-loaded data register and is the reading end of that register's output. It supports back-to-back words with no idle gap.

## Interface
- WIDTH, 8, data word width in bits (≥2)
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous and active-high. Single clock domain.
- data  input  WIDTH  word to transmit; sampled only on an accepted load
- load_valid  input  1  data is valid this cycle
- load_ready  output  1  serializer can accept a word this cycle
- sout  output  1  serial bit
- sout_valid  output  1  sout carries a frame bit this cycle
- done  output  1  one-cycle pulse coincident with the last frame bit
- busy  output  1  frame in progress (equals sout_valid)

## Operation
- States: IDLE, SHIFT.
- Accept: load_valid && load_ready on a rising edge. Data is captured into the shift register, and the bit counter is set to FRAME-1.
- FRAME = WIDTH, or WIDTH+1 when PARITY_EN is defined.
- IDLE:
  - load_ready=1, sout_valid=0, sout=0.
  - On accept, go to SHIFT.
- SHIFT:
  - Each cycle, drive the current bit, shift the register one position, and decrement the counter.
  - counter==0 is the last bit: done=1 and load_ready=1.
  - Accept in the last-bit cycle: reload and stay in SHIFT. The next frame starts the following cycle with no gap.
  - No accept in the last-bit cycle: go to IDLE.
  - load_ready=0 in every other SHIFT cycle. A load_valid asserted while load_ready=0 is ignored; the upstream side holds it.
- Bit order: MSB_FIRST=1 sends data[WIDTH-1] down to data[0]; MSB_FIRST=0 sends data[0] up to data[WIDTH-1].
- Counter width: $clog2(WIDTH+1). It never wraps; reaching 0 always terminates or reloads.
- data changes outside an accept cycle have no effect on a frame in flight.

## Timing
- Reset values: sout=0, sout_valid=0, busy=0, done=0, load_ready=1, state=IDLE, shift register=0, counter=0.
- Latency: first bit appears on sout the cycle after the accept edge.
- A frame occupies exactly FRAME consecutive cycles of sout_valid=1.
- done is high only in the last-bit cycle.
- load_ready is combinational from state/counter, with no dependence on load_valid. It is high in IDLE and in the last-bit cycle.
- rst has priority over everything, including mid-frame. On the next edge all outputs take reset values, remaining bits are discarded, and no done pulse is issued.
- rst asserted in the same cycle as an accept: reset wins and the word is dropped.
- Back-to-back throughput: one word per FRAME cycles.

## Configuration
- PARITY_EN:
  - Defined: an even-parity bit (XOR of all data bits, captured at accept) is appended after the last data bit. FRAME=WIDTH+1, and done moves to the parity cycle.
  - Undefined: no parity logic is present, FRAME=WIDTH.

## Structure
- Shared package serial_pkg:
  - state enum (IDLE, SHIFT)
  - default WIDTH constant
  - frame-length function of WIDTH and parity
- Single module, with no sub-module. The shift register, counter and FSM are small enough to sit together.

## Test plan
- Reset then single load, data=8'hA5, MSB_FIRST=1 -> sout sequence 1,0,1,0,0,1,0,1 over 8 cycles starting one cycle after accept; done in the 8th cycle; return to IDLE.
- MSB_FIRST=0, data=8'h01 -> sout 1,0,0,0,0,0,0,0; sout_valid high exactly 8 cycles.
- Back-to-back 8'hFF then 8'h00, load_valid held high -> 16 contiguous valid cycles (eight 1s then eight 0s); load_ready high only in IDLE and the 8th cycle; two done pulses.
- load_valid asserted with 8'h3C mid-frame while load_ready=0 -> ignored until the last-bit cycle, then accepted; the in-flight frame is unaltered.
- rst pulsed in cycle 4 of frame 8'hA5 -> next cycle sout_valid=0, sout=0, load_ready=1, no done; a subsequent load of 8'h81 transmits correctly.
- PARITY_EN defined, data=8'h07 -> 9 valid cycles, 9th bit=1; data=8'h03 -> 9th bit=0; done on the 9th cycle.
